// File: rtl/usb_bus_monitor_pkg.sv
// Shared definitions for the USB bus monitor: bus-state encodings, LineState and
// RxEvent codes, RXCMD field positions and the counter-width helper.
package usb_bus_monitor_pkg;

    typedef enum logic [2:0] {
        ST_DETACHED  = 3'd0,
        ST_ACTIVE    = 3'd1,
        ST_BUS_RST   = 3'd2,
        ST_SUSPENDED = 3'd3,
        ST_RESUMING  = 3'd4
    } bus_state_e;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;

    localparam logic [1:0] RXEV_NONE      = 2'b00;
    localparam logic [1:0] RXEV_ACTIVE    = 2'b01;
    localparam logic [1:0] RXEV_HOST_DISC = 2'b10;
    localparam logic [1:0] RXEV_ERROR     = 2'b11;

    localparam logic [1:0] VBUS_VALID_CODE = 2'b11;

    localparam int RXCMD_LS_LSB   = 0;
    localparam int RXCMD_VBUS_LSB = 2;
    localparam int RXCMD_EV_LSB   = 4;
    localparam int RXCMD_USED_W   = 6;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/usb_bus_monitor_ls_debounce.sv
// LineState stability filter: the output follows the input only after it has held
// the same value for CYCLES consecutive samples. Compiled only with USB_LS_DEBOUNCE_EN.
`ifdef USB_LS_DEBOUNCE_EN
module usb_ls_debounce #(
    parameter int CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] ls_raw_i,
    output logic [1:0] ls_o
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] TARGET = CW'(CYCLES);

    logic [1:0]    prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ls_q, ls_d;

    // cnt_d is the length of the current run of identical samples, this one included
    always_comb begin
        cnt_d = cnt_q;
        if (ls_raw_i != prev_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q != TARGET) begin
            cnt_d = cnt_q + 1'b1;
        end
        ls_d = (cnt_d == TARGET) ? ls_raw_i : ls_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
            cnt_q  <= '0;
            ls_q   <= '0;
        end else begin
            prev_q <= ls_raw_i;
            cnt_q  <= cnt_d;
            ls_q   <= ls_d;
        end
    end

    assign ls_o = ls_q;

endmodule
`endif

// File: rtl/usb_bus_monitor.sv
// Device-side USB bus monitor: decodes the ULPI RXCMD and tracks attach, bus reset,
// suspend and resume. Define USB_LS_DEBOUNCE_EN to filter LineState before the FSM.
module usb_bus_monitor
    import usb_bus_monitor_pkg::*;
#(
    parameter int RESET_CYCLES = 150,
    parameter int SUSP_CYCLES  = 180000
`ifdef USB_LS_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic       CLK_60M,
    input  logic       RST_A_USB,
    input  logic       READY,
    input  logic [7:0] RXCMD,
    output logic [1:0] LINE_STATE,
    output logic       VBUS_VALID,
    output logic       RX_ACTIVE,
    output logic       RX_ERROR,
    output logic [2:0] BUS_STATE,
    output logic       BUS_RESET,
    output logic       SUSPEND,
    output logic       RESUME
);

    localparam int CNT_W = cnt_width(RESET_CYCLES, SUSP_CYCLES);
    localparam logic [CNT_W-1:0] SE0_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SE0_MAX   = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(SUSP_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(SUSP_CYCLES);

    logic [RXCMD_USED_W-1:0] rxcmd_q;
    logic [1:0]              ls_raw, line_state, rx_event;
    logic                    vbus_valid, rx_active, rx_error;
    logic                    unused_rxcmd;

    bus_state_e       state_q, state_d;
    logic [CNT_W-1:0] se0_cnt_q, se0_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             bus_reset_q, bus_reset_d;
    logic             resume_q, resume_d;
    logic             override, se0_cond, idle_cond, se0_hit, idle_hit;

    assign unused_rxcmd = ^RXCMD[7:RXCMD_USED_W];

    always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
        if (RST_A_USB) begin
            rxcmd_q <= '0;
        end else begin
            rxcmd_q <= RXCMD[RXCMD_USED_W-1:0];
        end
    end

    assign ls_raw     = rxcmd_q[RXCMD_LS_LSB +: 2];
    assign rx_event   = rxcmd_q[RXCMD_EV_LSB +: 2];
    assign vbus_valid = (rxcmd_q[RXCMD_VBUS_LSB +: 2] == VBUS_VALID_CODE);
    assign rx_active  = (rx_event == RXEV_ACTIVE) || (rx_event == RXEV_ERROR);
    assign rx_error   = (rx_event == RXEV_ERROR);

`ifdef USB_LS_DEBOUNCE_EN
    usb_ls_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_ls_debounce (
        .clk_i    (CLK_60M),
        .rst_i    (RST_A_USB),
        .ls_raw_i (ls_raw),
        .ls_o     (line_state)
    );
`else
    assign line_state = ls_raw;
`endif

    // SE0 during a packet is EOP, so only idle-bus samples count toward reset/suspend
    assign override  = !READY || !vbus_valid;
    assign se0_cond  = (line_state == LS_SE0) && !rx_active;
    assign idle_cond = (line_state == LS_J) && !rx_active;
    assign se0_hit   = se0_cond && (se0_cnt_q == SE0_LAST);
    assign idle_hit  = idle_cond && (idle_cnt_q == IDLE_LAST);

    always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
        if (RST_A_USB) begin
            state_q     <= ST_DETACHED;
            se0_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            bus_reset_q <= 1'b0;
            resume_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            se0_cnt_q   <= se0_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            bus_reset_q <= bus_reset_d;
            resume_q    <= resume_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        se0_cnt_d  = '0;
        idle_cnt_d = '0;
        if (override) begin
            state_d = ST_DETACHED;
        end else begin
            case (state_q)
                ST_DETACHED:  state_d = ST_ACTIVE;
                ST_ACTIVE: begin
                    if (se0_hit)       state_d = ST_BUS_RST;
                    else if (idle_hit) state_d = ST_SUSPENDED;
                end
                ST_BUS_RST: begin
                    if (line_state != LS_SE0) state_d = ST_ACTIVE;
                end
                ST_SUSPENDED: begin
                    if (line_state == LS_K) state_d = ST_RESUMING;
                    else if (se0_hit)       state_d = ST_BUS_RST;
                end
                ST_RESUMING: begin
                    if (line_state != LS_K) state_d = ST_ACTIVE;
                end
                default:      state_d = ST_DETACHED;
            endcase

            if (((state_q == ST_ACTIVE) || (state_q == ST_SUSPENDED)) && se0_cond) begin
                se0_cnt_d = (se0_cnt_q == SE0_MAX) ? se0_cnt_q : se0_cnt_q + 1'b1;
            end
            if ((state_q == ST_ACTIVE) && idle_cond) begin
                idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus_reset_d = (state_d == ST_BUS_RST) && (state_q != ST_BUS_RST);
        resume_d    = (state_q == ST_SUSPENDED) && (state_d == ST_RESUMING);
        BUS_STATE   = state_q;
        SUSPEND     = (state_q == ST_SUSPENDED);
        BUS_RESET   = bus_reset_q;
        RESUME      = resume_q;
        LINE_STATE  = line_state;
        VBUS_VALID  = vbus_valid;
        RX_ACTIVE   = rx_active;
        RX_ERROR    = rx_error;
    end

endmodule

// File: tb/tb_usb_bus_monitor.sv
// Bench for usb_bus_monitor: expected output vectors go into a queue as stimulus
// is applied and are popped against the DUT once the response is due.
module tb_usb_bus_monitor;

    localparam int RST_N  = 150;
    localparam int SUSP_N = 200;
`ifdef USB_LS_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [7:0] rxcmd;
    logic [1:0] line_state;
    logic       vbus_valid, rx_active, rx_error;
    logic [2:0] bus_state;
    logic       bus_reset, suspend, resume;

    typedef struct {
        string       name;
        logic [10:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   n_rst_pulse = 0;
    int   n_res_pulse = 0;
    int   p0, p1;

    always #5 clk = ~clk;

    usb_bus_monitor #(
        .RESET_CYCLES (RST_N),
        .SUSP_CYCLES  (SUSP_N)
    ) dut (
        .CLK_60M    (clk),
        .RST_A_USB  (rst),
        .READY      (ready),
        .RXCMD      (rxcmd),
        .LINE_STATE (line_state),
        .VBUS_VALID (vbus_valid),
        .RX_ACTIVE  (rx_active),
        .RX_ERROR   (rx_error),
        .BUS_STATE  (bus_state),
        .BUS_RESET  (bus_reset),
        .SUSPEND    (suspend),
        .RESUME     (resume)
    );

    always @(negedge clk) begin
        if (bus_reset === 1'b1) n_rst_pulse++;
        if (resume === 1'b1)    n_res_pulse++;
    end

    function automatic logic [10:0] obs();
        return {line_state, vbus_valid, rx_active, rx_error, bus_state, bus_reset, suspend, resume};
    endfunction

    function automatic logic [10:0] mk(logic [1:0] ls, logic vb, logic ra, logic re,
                                       logic [2:0] st, logic br, logic su, logic rs);
        return {ls, vb, ra, re, st, br, su, rs};
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b1; rxcmd = 8'h0D;
        exp_q.push_back('{"reset_outputs", mk(2'b00, 0, 0, 0, 3'd0, 0, 0, 0)});
        cyc(3);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end

        rst = 1'b0;
        exp_q.push_back('{"release_1cyc", mk((DB == 0) ? 2'b01 : 2'b00, 1, 0, 0, 3'd0, 0, 0, 0)});
        exp_q.push_back('{"release_2cyc", mk((DB == 0) ? 2'b01 : 2'b00, 1, 0, 0, 3'd1, 0, 0, 0)});
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(DB);
    endtask

    task automatic test_bus_reset();
        p0 = n_rst_pulse;
        rxcmd = 8'h0C;
        exp_q.push_back('{"se0_149_samples", mk(2'b00, 1, 0, 0, 3'd1, 0, 0, 0)});
        exp_q.push_back('{"se0_150_pulse",   mk(2'b00, 1, 0, 0, 3'd2, 1, 0, 0)});
        exp_q.push_back('{"bus_rst_held",    mk(2'b00, 1, 0, 0, 3'd2, 0, 0, 0)});
        cyc(RST_N + DB);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(20);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        total++;
        if (n_rst_pulse - p0 != 1) begin
            bad++; $display("FAIL bus_reset_pulse_count: got %0d want 1", n_rst_pulse - p0);
        end

        rxcmd = 8'h0D;
        exp_q.push_back('{"bus_rst_exit", mk(2'b01, 1, 0, 0, 3'd1, 0, 0, 0)});
        cyc(2 + DB);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    endtask

    task automatic test_short_se0();
        p0 = n_rst_pulse;
        rxcmd = 8'h0C;
        cyc(RST_N - 1);
        rxcmd = 8'h0D;
        exp_q.push_back('{"se0_149_no_reset", mk(2'b01, 1, 0, 0, 3'd1, 0, 0, 0)});
        cyc(DB + 10);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        total++;
        if (n_rst_pulse != p0) begin
            bad++; $display("FAIL short_se0_pulses: got %0d want 0", n_rst_pulse - p0);
        end
    endtask

    task automatic test_eop();
        p0 = n_rst_pulse;
        rxcmd = 8'h1C;
        exp_q.push_back('{"eop_no_reset", mk(2'b00, 1, 1, 0, 3'd1, 0, 0, 0)});
        cyc(300);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        total++;
        if (n_rst_pulse != p0) begin
            bad++; $display("FAIL eop_pulses: got %0d want 0", n_rst_pulse - p0);
        end
        rxcmd = 8'h3C;
        exp_q.push_back('{"rx_error", mk(2'b00, 1, 1, 1, 3'd1, 0, 0, 0)});
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        rxcmd = 8'h2C;
        exp_q.push_back('{"host_disc_event", mk(2'b00, 1, 0, 0, 3'd1, 0, 0, 0)});
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    endtask

    task automatic test_suspend_resume();
        rxcmd = 8'h0D;
        exp_q.push_back('{"idle_199_samples", mk(2'b01, 1, 0, 0, 3'd1, 0, 0, 0)});
        exp_q.push_back('{"suspend_entry",    mk(2'b01, 1, 0, 0, 3'd3, 0, 1, 0)});
        cyc(SUSP_N + DB);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end

        p1 = n_res_pulse;
        rxcmd = 8'h0E;
        exp_q.push_back('{"k_seen_still_susp", mk(2'b10, 1, 0, 0, 3'd3, 0, 1, 0)});
        exp_q.push_back('{"resume_pulse",      mk(2'b10, 1, 0, 0, 3'd4, 0, 0, 1)});
        exp_q.push_back('{"resuming_held",     mk(2'b10, 1, 0, 0, 3'd4, 0, 0, 0)});
        cyc(1 + DB);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        total++;
        if (n_res_pulse - p1 != 1) begin
            bad++; $display("FAIL resume_pulse_count: got %0d want 1", n_res_pulse - p1);
        end

        rxcmd = 8'h0D;
        exp_q.push_back('{"resume_exit", mk(2'b01, 1, 0, 0, 3'd1, 0, 0, 0)});
        cyc(2 + DB);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    endtask

    task automatic test_suspend_bus_reset();
        exp_q.push_back('{"resuspend", mk(2'b01, 1, 0, 0, 3'd3, 0, 1, 0)});
        cyc(SUSP_N + DB + 5);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end

        rxcmd = 8'h0C;
        exp_q.push_back('{"susp_se0_149",   mk(2'b00, 1, 0, 0, 3'd3, 0, 1, 0)});
        exp_q.push_back('{"susp_se0_reset", mk(2'b00, 1, 0, 0, 3'd2, 1, 0, 0)});
        cyc(RST_N + DB);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        rxcmd = 8'h0D;
        cyc(2 + DB);
    endtask

    task automatic test_override();
        p0 = n_rst_pulse; p1 = n_res_pulse;
        exp_q.push_back('{"susp_before_ready_drop", mk(2'b01, 1, 0, 0, 3'd3, 0, 1, 0)});
        cyc(SUSP_N + DB + 5);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        ready = 1'b0;
        exp_q.push_back('{"ready_drop", mk(2'b01, 1, 0, 0, 3'd0, 0, 0, 0)});
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        ready = 1'b1;
        exp_q.push_back('{"ready_back", mk(2'b01, 1, 0, 0, 3'd1, 0, 0, 0)});
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end

        cyc(SUSP_N + DB + 5);
        rxcmd = 8'h01;
        exp_q.push_back('{"vbus_drop_lag",      mk(2'b01, 0, 0, 0, 3'd3, 0, 1, 0)});
        exp_q.push_back('{"vbus_drop_detached", mk(2'b01, 0, 0, 0, 3'd0, 0, 0, 0)});
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        total++;
        if ((n_rst_pulse != p0) || (n_res_pulse != p1)) begin
            bad++; $display("FAIL override_pulses: got rst=%0d res=%0d want 0 0", n_rst_pulse - p0, n_res_pulse - p1);
        end

        rxcmd = 8'h0D;
        exp_q.push_back('{"vbus_back", mk(2'b01, 1, 0, 0, 3'd1, 0, 0, 0)});
        cyc(2 + DB);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end

        // SE0 threshold and READY loss land on the same edge
        p0 = n_rst_pulse;
        rxcmd = 8'h0C;
        cyc(RST_N + DB);
        ready = 1'b0;
        exp_q.push_back('{"override_beats_reset", mk(2'b00, 1, 0, 0, 3'd0, 0, 0, 0)});
        cyc(1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(2);
        total++;
        if (n_rst_pulse != p0) begin
            bad++; $display("FAIL override_reset_pulse: got %0d want 0", n_rst_pulse - p0);
        end
        ready = 1'b1; rxcmd = 8'h0D;
        exp_q.push_back('{"override_recover", mk(2'b01, 1, 0, 0, 3'd1, 0, 0, 0)});
        cyc(2 + DB);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
    endtask

    task automatic test_async_reset();
        rxcmd = 8'h0C;
        exp_q.push_back('{"pre_async_pulse",  mk(2'b00, 1, 0, 0, 3'd2, 1, 0, 0)});
        exp_q.push_back('{"async_reset_mid",  mk(2'b00, 0, 0, 0, 3'd0, 0, 0, 0)});
        exp_q.push_back('{"post_async_active", mk(2'b00, 1, 0, 0, 3'd1, 0, 0, 0)});
        cyc(RST_N + DB + 1);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        #2 rst = 1'b1;
        #1;
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(1);
        rst = 1'b0;
        cyc(2);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        rxcmd = 8'h0D;
        cyc(2 + DB);
    endtask

`ifdef USB_LS_DEBOUNCE_EN
    task automatic test_debounce();
        exp_q.push_back('{"db_suspended", mk(2'b01, 1, 0, 0, 3'd3, 0, 1, 0)});
        cyc(SUSP_N + DB + 5);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        p1 = n_res_pulse;
        rxcmd = 8'h0E;
        cyc(3);
        rxcmd = 8'h0D;
        exp_q.push_back('{"glitch_no_resume", mk(2'b01, 1, 0, 0, 3'd3, 0, 1, 0)});
        cyc(DB + 5);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        total++;
        if (n_res_pulse != p1) begin
            bad++; $display("FAIL glitch_resume_count: got %0d want 0", n_res_pulse - p1);
        end
        rxcmd = 8'h0E;
        exp_q.push_back('{"db_resume_pulse", mk(2'b10, 1, 0, 0, 3'd4, 0, 0, 1)});
        cyc(2 + DB);
        e = exp_q.pop_front(); total++;
        if (obs() !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(), e.v); end
        cyc(3);
        rxcmd = 8'h0D;
        cyc(2 + DB);
        total++;
        if (n_res_pulse - p1 != 1) begin
            bad++; $display("FAIL db_resume_count: got %0d want 1", n_res_pulse - p1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bus_reset();
        test_short_se0();
        test_eop();
        test_suspend_resume();
        test_suspend_bus_reset();
        test_override();
        test_async_reset();
`ifdef USB_LS_DEBOUNCE_EN
        test_debounce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
